// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one valid/ready resource port
// among NUM_REQ requesters; priority rotates after each completed burst.
module rr_resource_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*LEN_W-1:0] len_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [IDX_W-1:0]         owner_o,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [LEN_W-1:0]         beat_cnt_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_last_ptr;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic               r_done;

  logic               w_found;
  logic [IDX_W-1:0]   w_winner;
  logic [LEN_W-1:0]   w_win_len;
  logic               w_last_beat;

  // Requester index visited at search step 'off', starting just above 'last'.
  function automatic int unsigned rr_idx(input logic [IDX_W-1:0] last,
                                         input int unsigned off);
    int unsigned s;
    s = 32'(last) + 32'd1 + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  always_comb begin
    w_found   = 1'b0;
    w_winner  = '0;
    w_win_len = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_i[rr_idx(r_last_ptr, i)]) begin
        w_found   = 1'b1;
        w_winner  = IDX_W'(rr_idx(r_last_ptr, i));
        w_win_len = len_i[rr_idx(r_last_ptr, i)*LEN_W +: LEN_W];
      end
    end
  end

  assign w_last_beat = res_ready_i && (r_beat_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_found)     w_next_state = XFER;
      XFER:    if (w_last_beat) w_next_state = IDLE;
      default:                  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= '0;
      r_last_ptr <= IDX_W'(NUM_REQ - 1);
      r_beat_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_owner    <= w_winner;
            r_beat_cnt <= w_win_len;
          end
        end
        XFER: begin
          if (res_ready_i) begin
            if (r_beat_cnt != '0) begin
              r_beat_cnt <= r_beat_cnt - 1'b1;
            end else begin
              r_done     <= 1'b1;
              r_last_ptr <= r_owner;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Grant, valid and busy all derive from the registered state, so they stay coherent.
  always_comb begin
    busy_o      = (r_state == XFER);
    res_valid_o = (r_state == XFER);
    gnt_o       = (r_state == XFER) ? (NUM_REQ'(1) << r_owner) : '0;
    owner_o     = r_owner;
    beat_cnt_o  = r_beat_cnt;
    done_o      = r_done;
  end

endmodule

// File: doc/rr_resource_arbiter.md
# rr_resource_arbiter

Round-robin arbiter and burst sequencer that shares one downstream resource port among `NUM_REQ` requesters. Each requester asks for a burst of `len+1` beats. The block grants one requester at a time, drives the shared port's valid/ready handshake for the whole burst, and rotates priority after each completed burst. It is the DUT the team's class-based benches drive, with one requester agent per port.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `LEN_W`, default 4: width of each burst-length field. A burst is `len+1` beats, 1..2^LEN_W.
- `IDX_W`, default `$clog2(NUM_REQ)`: width of the owner index. Derived; do not override.

Ports (name, direction, width, meaning):
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_i`, input, `NUM_REQ`: request lines, one per requester.
- `len_i`, input, `NUM_REQ*LEN_W`: burst length minus one. Requester k uses bits `[k*LEN_W +: LEN_W]`.
- `gnt_o`, output, `NUM_REQ`: one-hot grant, held for the whole burst.
- `owner_o`, output, `IDX_W`: index of the current grant holder.
- `res_valid_o`, output, 1: a beat is offered to the shared resource.
- `res_ready_i`, input, 1: the resource accepts the beat.
- `beat_cnt_o`, output, `LEN_W`: beats remaining after the current one.
- `busy_o`, output, 1: a burst is in progress.
- `done_o`, output, 1: one-cycle pulse on the final accepted beat.

## Operation
State machine with two states: `IDLE` and `XFER`.

**IDLE**
- If `req_i` is nonzero, select a winner by round-robin.
  - The search starts at `(last_ptr+1) mod NUM_REQ` and moves upward with wrap-around.
  - The first set bit wins.
- On that edge:
  - `gnt_o` ← onehot(winner), `owner_o` ← winner.
  - `beat_cnt_o` ← winner's `len_i` field.
  - `busy_o` ← 1, `res_valid_o` ← 1; go to `XFER`.
- `len_i` is sampled only at grant time. Later changes are ignored.

**XFER**
- A beat is accepted when `res_valid_o && res_ready_i` in the same cycle.
- Accepted beat with `beat_cnt_o != 0`: decrement `beat_cnt_o` and stay in `XFER`.
- Accepted beat with `beat_cnt_o == 0`:
  - `done_o` pulses 1 for the next cycle.
  - `last_ptr` ← owner.
  - Clear `gnt_o`, `res_valid_o` and `busy_o`; go to `IDLE`.
- `res_ready_i` low: hold all state; `res_valid_o` stays 1. There is no timeout.
- The owner dropping `req_i` mid-burst is ignored; the burst always runs to completion.
- Requests from other requesters during `XFER` are not evaluated until the next `IDLE` cycle.

**Priority pointer**
- Reset value of `last_ptr` is `NUM_REQ-1`, so requester 0 has top priority after reset.
- `last_ptr` updates only on burst completion, never on grant.

**Arithmetic**
- `beat_cnt_o` is unsigned `LEN_W` bits. It never underflows, because the transition to `IDLE` occurs at 0.

## Timing
Reset values, applied asynchronously while `rst_n` = 0:
- `gnt_o` = 0, `owner_o` = 0, `res_valid_o` = 0.
- `beat_cnt_o` = 0, `busy_o` = 0, `done_o` = 0.
- `last_ptr` = `NUM_REQ-1`, state = `IDLE`.

Latency and throughput:
- Grant latency: request seen on edge N → `gnt_o`/`res_valid_o` high after edge N, one cycle.
- Burst of L+1 beats with ready held high: `XFER` lasts exactly L+1 cycles.
- `done_o` is registered. It is high in the cycle after the last handshake, coinciding with `IDLE`.
- There is one mandatory `IDLE` cycle between bursts. Back-to-back bursts therefore use L+2 cycles each.
- Simultaneous last beat and new requests: the new requests are arbitrated in the following `IDLE` cycle using the updated `last_ptr`.

Invariants:
- `gnt_o` is always zero or one-hot.
- `res_valid_o` == `busy_o` == (`gnt_o` != 0).

Reset mid-burst: all outputs clear immediately, and there is no `done_o` pulse.

## Test plan
- **Single burst.** `req_i`=0001, `len`=2, ready=1.
  - Required: `gnt_o`=0001 one cycle later, 3 valid cycles with `beat_cnt_o` = 2,1,0.
  - Then `done_o`=1 for one cycle, `busy_o`=0.
- **Rotation.** `req_i`=1111 held, all `len`=0.
  - Required: grants in order 0001, 0010, 0100, 1000, 0001, with 2 cycles per grant.
- **Wrap-around.** Requester 3 finishes a burst, then `req_i`=1001.
  - Required: requester 0 is granted next, not 3.
- **Back-pressure.** `len`=1; `res_ready_i` low for 5 cycles mid-burst.
  - Required: `res_valid_o` and `beat_cnt_o` hold; `done_o` only after the 2nd accepted beat.
  - Owner dropping `req_i` during the stall has no effect.
- **Maximum length.** `len`=15 with `LEN_W`=4.
  - Required: exactly 16 accepted beats before `done_o`.
  - Changing `len_i` mid-burst has no effect.
- **Reset mid-burst.** `rst_n` low during beat 2 of 4.
  - Required: all outputs 0 immediately and no `done_o`.
  - After release, `req_i`=1111 grants requester 0.
